// File: rtl/md_sequencer.sv
// md_sequencer: iterative RV32M multiply/divide unit beside the execute ALU.
// Captures forwarded operands on an M-op in execute, runs 32 shift-add
// multiply or restoring divide steps on magnitudes, sign-corrects in FIX and
// returns one result per op while stalling the front of the pipeline.
//
// Ports:
//   clk        pipeline clock, rising edge
//   rst        asynchronous active-low reset
//   StartE     M-op valid in execute (held while stalled)
//   MDOpE      funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   Src_A/B    forwarded rs1/rs2 values
//   FlushE     kill the execute-stage op
//   StallMD    freeze IF/ID/ID-EX (combinational)
//   BusyE      registered, high in CALC/FIX/DONE
//   DoneE      one-cycle pulse, MDResultE valid
//   MDResultE  result, held until the next DoneE
//
// Build option: MD_ZERO_SKIP_EN -- multiplies with a zero operand skip CALC.
module md_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned STEPS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StartE,
  input  logic [2:0]      MDOpE,
  input  logic [XLEN-1:0] Src_A,
  input  logic [XLEN-1:0] Src_B,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            BusyE,
  output logic            DoneE,
  output logic [XLEN-1:0] MDResultE
);
  localparam int unsigned CW = $clog2(STEPS);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d, spec_q, spec_d;
  logic              done_q, done_d, busy_q, busy_d;

  logic              a_signed, b_signed, sa_in, sb_in;
  logic              div_zero, div_ovf, mul_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, rem_sh, rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  // Operand decode at start: MULHSU treats only rs1 as signed
  always_comb begin
    a_signed = MDOpE inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
    b_signed = MDOpE inside {3'b000, 3'b001, 3'b100, 3'b110};
    sa_in    = a_signed & Src_A[XLEN-1];
    sb_in    = b_signed & Src_B[XLEN-1];
    mag_a    = sa_in ? -Src_A : Src_A;
    mag_b    = sb_in ? -Src_B : Src_B;
    div_zero = MDOpE[2] && (Src_B == '0);
    div_ovf  = (MDOpE == 3'b100 || MDOpE == 3'b110) &&
               (Src_A == {1'b1, {(XLEN-1){1'b0}}}) && (Src_B == '1);
`ifdef MD_ZERO_SKIP_EN
    mul_zero = !MDOpE[2] && (Src_A == '0 || Src_B == '0);
`else
    mul_zero = 1'b0;
`endif
  end

  // One iteration. Multiply: opb is the right-shifting multiplier, the carry
  // of the upper-half add shifts into bit 63. Divide: opa is the dividend,
  // shifted left so its MSB feeds the partial remainder in acc[63:32].
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
    rem_sh   = {acc_q[2*XLEN-1:XLEN], opa_q[XLEN-1]};
    rem_ge   = rem_sh >= {1'b0, opb_q};
    rem_diff = rem_sh - {1'b0, opb_q};
  end

  // Sign correction; special cases preload acc with the final answer
  always_comb begin
    prod_fix = ((sa_q ^ sb_q) && !spec_q) ? -acc_q : acc_q;
    quot_fix = ((sa_q ^ sb_q) && !spec_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = (sa_q && !spec_q) ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    spec_d   = spec_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (StartE) begin
          op_d    = MDOpE;
          sa_d    = sa_in;
          sb_d    = sb_in;
          opa_d   = mag_a;
          opb_d   = mag_b;
          acc_d   = '0;
          cnt_d   = '0;
          spec_d  = 1'b0;
          state_d = S_CALC;
          if (div_zero) begin
            acc_d   = {Src_A, {XLEN{1'b1}}};
            spec_d  = 1'b1;
            state_d = S_FIX;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            spec_d  = 1'b1;
            state_d = S_FIX;
          end else if (mul_zero) begin
            spec_d  = 1'b1;
            state_d = S_FIX;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[2]) begin
          acc_d = {(rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                   acc_q[XLEN-2:0], rem_ge};
          opa_d = opa_q << 1;
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          opb_d = opb_q >> 1;
        end
        if (cnt_q == CW'(STEPS-1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (FlushE) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Gated by rst so a held StartE cannot stall the pipe during reset
  assign StallMD   = rst & ~FlushE &
                     (((state_q == S_IDLE) & StartE) | (state_q == S_CALC) |
                      (state_q == S_FIX));
  assign BusyE     = busy_q;
  assign DoneE     = done_q;
  assign MDResultE = result_q;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Iterative RV32M multiply/divide sequencer beside the execute stage ALU. When an M-extension op is in execute, it captures the forwarded operands, runs a 32-step shift-add multiply or restoring divide, applies sign correction, and returns a 32-bit result. While busy it stalls the front of the pipeline through the hazard unit, so execute and memory see one result per op.

## Interface
Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- STEPS, 32, iteration count; equals XLEN

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- StartE  in  1  M-op valid in execute; held high while the op is stalled in execute
- MDOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Src_A  in  32  forwarded rs1 value
- Src_B  in  32  forwarded rs2 value
- FlushE  in  1  kill the execute-stage op
- StallMD  out  1  to the hazard unit; freezes IF, ID and the ID/EX register
- BusyE  out  1  sequencer not in IDLE
- DoneE  out  1  one-cycle pulse; MDResultE valid
- MDResultE  out  32  result; holds the last value until the next DoneE

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, StartE=1, FlushE=0:
  - latch the op, operand signs and magnitudes (signed ops take absolute values; MULHSU takes only A as signed); clear the 64-bit accumulator and the 5-bit counter.
  - next state is CALC, or FIX for a special case.
- Special cases at start:
  - DIV/DIVU/REM/REMU with Src_B=0: quotient 32'hFFFFFFFF, remainder = Src_A.
  - DIV/REM with Src_A=32'h80000000 and Src_B=32'hFFFFFFFF: quotient 32'h80000000, remainder 0.
- CALC: one step per cycle; the counter increments and the state moves to FIX when the counter reaches 31.
  - Multiply step: if the multiplier LSB is 1, add the multiplicand into the upper half; shift right one.
  - Divide step: shift the remainder:quotient pair left; subtract the divisor when the remainder is at least the divisor; set the quotient LSB.
- FIX:
  - Negate the product if the operand signs differ (MUL/MULH/MULHSU).
  - Negate the quotient if the signs differ (DIV); give the remainder the dividend's sign (REM).
  - Select the result: low word for MUL, high word for MULH*, quotient for DIV*, remainder for REM*. Register it into MDResultE.
- DONE: DoneE=1; StartE is ignored, because it is still the same instruction. Next state is always IDLE.
- Arithmetic is modulo 2^32 (two's complement negation); no overflow flags.
- FlushE=1 in any state: next state IDLE, no DoneE, MDResultE unchanged, StallMD forced 0 that cycle.

## Timing
- Reset (async, rst=0): state IDLE, counter 0, accumulator 0, MDResultE=0, DoneE=0, BusyE=0, StallMD=0.
- Reset while an op is in progress aborts it immediately; no DoneE follows.
- StallMD = ((IDLE & StartE) | CALC | FIX) & ~FlushE. It is combinational, so the start cycle is already stalled.
- Normal op: start at cycle 0, CALC cycles 1–32, FIX at cycle 33, DONE at cycle 34.
  - StallMD is high for cycles 0–33 (34 cycles).
  - DoneE and MDResultE are valid at cycle 34, and the pipeline advances that cycle.
- Special case: start at cycle 0, FIX at cycle 1, DONE at cycle 2; StallMD is high for cycles 0–1.
- A new StartE is accepted only in IDLE. Back-to-back M-ops therefore start one cycle after DONE.
- BusyE is registered: high in CALC, FIX and DONE.

## Configuration
- MD_ZERO_SKIP_EN:
  - Defined: a multiply op with Src_A=0 or Src_B=0 goes IDLE→FIX with a zero product; DoneE at cycle 2.
  - Undefined: zero operands run the full 32 CALC cycles; DoneE at cycle 34. The result is identical either way.

## Test plan
- MUL 7×(−3): DoneE at cycle 34; MDResultE=32'hFFFFFFEB; StallMD high for exactly 34 cycles.
- MULHU 32'hFFFFFFFF×32'hFFFFFFFF → 32'hFFFFFFFE. MULH 32'h80000000×32'h80000000 → 32'h40000000. MULHSU −1×2 → 32'hFFFFFFFF.
- DIV −7/2 → 32'hFFFFFFFD; REM −7/2 → 32'hFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 32'hFFFFFFFF and REM 5/0 → 5, both at cycle 2. DIV 32'h80000000/−1 → 32'h80000000 and REM → 0, also at cycle 2.
- FlushE at cycle 10 of a DIV: state IDLE at cycle 11; no DoneE; MDResultE keeps its prior value. rst low at cycle 20 of a MUL: all outputs 0 immediately.
- MUL 0×5: DoneE at cycle 2 with MD_ZERO_SKIP_EN defined, at cycle 34 without; result 0 in both builds.
